// File: rtl/divider_24bit_if.sv
// divider_24bit_if: operand/result handshake bundle
// for the 24-bit restoring divider.
interface divider_24bit_if #(
  parameter int N    = 24,
  parameter int FRAC = 24
);
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        A;
  logic [N-1:0]        B;
  logic                out_valid;
  logic                out_ready;
  logic [N+FRAC-1:0]   QUO;
  logic [N-1:0]        REM;
  logic                sticky;
  logic                dbz;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid,
    input  QUO, REM, sticky, dbz
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid,
    output QUO, REM, sticky, dbz
  );
endinterface

// File: rtl/divider_24bit.sv
// divider_24bit: radix-2 restoring unsigned divider, one quotient bit per clock.
// Option DIVIDER_24BIT_EARLY_EXIT_EN: zero operands finish at the accept edge.
module divider_24bit #(
  parameter int N    = 24,
  parameter int FRAC = 24
) (
  input  logic            clk,
  input  logic            rstn,
  divider_24bit_if.slave  bus
);
  localparam int QW = N + FRAC;
  localparam int CW = $clog2(QW);

`ifdef DIVIDER_24BIT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_rem;
  logic [QW-1:0]   r_dvd;
  logic [QW-1:0]   r_quo;
  logic [CW-1:0]   r_cnt;
  logic            r_bz;
  logic [QW-1:0]   r_quo_o;
  logic [N-1:0]    r_rem_o;
  logic            r_sticky;
  logic            r_dbz;

  logic [N:0]      w_p;
  logic            w_ge;
  logic [N-1:0]    w_sub;
  logic [N-1:0]    w_rem_nx;
  logic [QW-1:0]   w_quo_nx;
  logic            w_acc;
  logic            w_b_zero;
  logic            w_zero_op;

  // The remainder is always < B, so N bits hold it;
  // only the shifted partial p needs the extra bit.
  assign w_p      = {r_rem, r_dvd[QW-1]};
  assign w_ge     = w_p >= {1'b0, r_b};
  assign w_sub    = w_p[N-1:0] - r_b;
  assign w_rem_nx = w_ge ? w_sub : w_p[N-1:0];
  assign w_quo_nx = {r_quo[QW-2:0], w_ge};

  assign w_acc     = bus.in_valid && bus.in_ready;
  assign w_b_zero  = (bus.B == '0);
  assign w_zero_op = (bus.A == '0) || w_b_zero;

  assign bus.in_ready  = (r_state == S_IDLE) && rstn;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.QUO       = r_quo_o;
  assign bus.REM       = r_rem_o;
  assign bus.sticky    = r_sticky;
  assign bus.dbz       = r_dbz;

  // Control FSM with datapath: accept, iterate, hold result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_quo_o  <= '0;
      r_rem_o  <= '0;
      r_sticky <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_b   <= bus.B;
            r_dvd <= {bus.A, {FRAC{1'b0}}};
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CW'(QW - 1);
            r_bz  <= w_b_zero;
            if (EARLY && w_zero_op) begin
              r_state  <= S_DONE;
              r_quo_o  <= w_b_zero ? '1 : '0;
              r_rem_o  <= '0;
              r_sticky <= w_b_zero;
              r_dbz    <= w_b_zero;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_dvd <= {r_dvd[QW-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            if (r_bz) begin
              r_quo_o  <= '1;
              r_rem_o  <= '0;
              r_sticky <= 1'b1;
              r_dbz    <= 1'b1;
            end else begin
              r_quo_o  <= w_quo_nx;
              r_rem_o  <= w_rem_nx;
              r_sticky <= |w_rem_nx;
              r_dbz    <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_24bit.sv
// tb_divider_24bit: directed vectors plus an arithmetic
// reference model checked on every cycle out_valid is high.
module tb_divider_24bit;
  localparam int N    = 24;
  localparam int FRAC = 24;
  localparam int QW   = N + FRAC;

`ifdef DIVIDER_24BIT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Edges after the accept edge until out_valid is seen.
  // Early exit raises out_valid on the accept edge itself.
  localparam int ZLAT = EARLY ? 0 : QW;

  typedef struct {
    logic [47:0] quo;
    logic [23:0] rem;
    logic        sticky;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q[$];
  bit   seen = 1'b0;

  divider_24bit_if #(.N(N), .FRAC(FRAC)) bus ();

  divider_24bit #(.N(N), .FRAC(FRAC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic exp_t model(input logic [23:0] a,
                                 input logic [23:0] b);
    exp_t        e;
    logic [47:0] num;
    logic [47:0] den;
    logic [47:0] r;
    num = {a, 24'h0};
    den = {24'h0, b};
    if (b == 24'h0) begin
      e.quo    = '1;
      e.rem    = '0;
      e.sticky = 1'b1;
      e.dbz    = 1'b1;
    end else begin
      e.quo    = num / den;
      r        = num % den;
      e.rem    = r[23:0];
      e.sticky = (r != 48'h0);
      e.dbz    = 1'b0;
    end
    e.lat = (a == 24'h0 || b == 24'h0) ? ZLAT : QW;
    e.acc = 0;
    return e;
  endfunction

  // Scoreboard: push on handshake, compare while out_valid.
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!seen) chk("latency", cyc - q[0].acc, q[0].lat);
          seen = 1'b1;
          chk("quo", bus.QUO, q[0].quo);
          chk("rem", bus.REM, q[0].rem);
          chk("sticky", bus.sticky, q[0].sticky);
          chk("dbz", bus.dbz, q[0].dbz);
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin : acc_b
        exp_t e;
        e     = model(bus.A, bus.B);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic run_op(input  logic [23:0] a,
                        input  logic [23:0] b,
                        input  int          hold,
                        output logic [47:0] quo,
                        output logic [23:0] rem,
                        output logic        sticky,
                        output logic        dbz,
                        output int          lat);
    int t;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_pre", bus.in_ready, 1);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = 24'($urandom);
    bus.B        = 24'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", bus.out_valid, 1);
    quo    = bus.QUO;
    rem    = bus.REM;
    sticky = bus.sticky;
    dbz    = bus.dbz;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_quo", bus.QUO, quo);
      chk("hold_rem", bus.REM, rem);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] quo;
    logic [23:0] rem;
    logic        st;
    logic        dz;
    int          lat;
    int          t;
    bit          any_v;
    int          acc_c[3];
    logic [23:0] pa[3];
    logic [23:0] pb[3];

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_quo", bus.QUO, 0);
    chk("rst_rem", bus.REM, 0);
    chk("rst_sticky", bus.sticky, 0);
    chk("rst_dbz", bus.dbz, 0);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);

    run_op(24'h800000, 24'h800000, 0, quo, rem, st, dz, lat);
    chk("t1_quo", quo, 48'h000001000000);
    chk("t1_rem", rem, 0);
    chk("t1_sticky", st, 0);
    chk("t1_dbz", dz, 0);
    chk("t1_lat", lat, 48);

    run_op(24'h800000, 24'hC00000, 0, quo, rem, st, dz, lat);
    chk("t2_quo", quo, 48'h000000AAAAAA);
    chk("t2_rem", rem, 24'h800000);
    chk("t2_sticky", st, 1);

    run_op(24'hC00000, 24'h800000, 5, quo, rem, st, dz, lat);
    chk("t3_quo", quo, 48'h000001800000);
    chk("t3_rem", rem, 0);
    chk("t3_sticky", st, 0);

    run_op(24'h123456, 24'h000000, 0, quo, rem, st, dz, lat);
    chk("dbz_flag", dz, 1);
    chk("dbz_quo", quo, 48'hFFFFFFFFFFFF);
    chk("dbz_rem", rem, 0);
    chk("dbz_sticky", st, 1);
    chk("dbz_lat", lat, ZLAT);

    run_op(24'h000000, 24'h000005, 0, quo, rem, st, dz, lat);
    chk("a0_quo", quo, 0);
    chk("a0_rem", rem, 0);
    chk("a0_sticky", st, 0);
    chk("a0_dbz", dz, 0);
    chk("a0_lat", lat, ZLAT);

    // Abort mid-run with a one-edge reset pulse.
    bus.A        = 24'hFFFFFF;
    bus.B        = 24'h800001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_quo", bus.QUO, 0);
    rstn = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    any_v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) any_v = 1'b1;
    end
    chk("abort_no_valid", any_v, 0);

    run_op(24'h800000, 24'h800000, 0, quo, rem, st, dz, lat);
    chk("t5_quo", quo, 48'h000001000000);
    chk("t5_rem", rem, 0);

    // Back-to-back with in_valid held and out_ready tied high.
    pa[0] = 24'hFFFFFF; pb[0] = 24'h800001;
    pa[1] = 24'hABCDEF; pb[1] = 24'h123457;
    pa[2] = 24'h000001; pb[2] = 24'hFFFFFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.A        = pa[i];
      bus.B        = pb[i];
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      @(posedge clk); #1;
      acc_c[i] = cyc;
    end
    bus.in_valid = 1'b0;
    chk("b2b_gap1", acc_c[1] - acc_c[0], QW + 2);
    chk("b2b_gap2", acc_c[2] - acc_c[1], QW + 2);
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
